// File: rtl/lead_norm_seq.sv
// Sequential leading-zero / redundant-sign-bit normalizer: returns count and left-normalized word.
// Optional `LEAD_NORM_SKIP4_EN: shift by 4 in one BUSY cycle when four redundant bits are at the top.
module lead_norm_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [7:0]       r_cnt;
  logic             r_signed;
  logic [WIDTH-1:0] r_out_data;
  logic [7:0]       r_out_cnt;

  logic             w_accept;
  logic             w_in_zero;
  logic             w_in_ones;
  logic             w_special;
  logic [7:0]       w_spec_cnt;
  logic [WIDTH-1:0] w_spec_data;
  logic             w_stop;
  logic             w_skip;
  logic [WIDTH-1:0] w_work_nxt;
  logic [7:0]       w_cnt_nxt;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_in_zero = (in_data == '0);
  assign w_in_ones = &in_data;

  // Inputs with no terminating bit pattern are resolved on the accept edge.
  assign w_special   = w_in_zero || (in_signed && w_in_ones);
  assign w_spec_cnt  = in_signed ? 8'(WIDTH - 1) : 8'(WIDTH);
  assign w_spec_data = (in_signed && w_in_ones) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  assign w_stop = r_signed ? (r_work[WIDTH-1] != r_work[WIDTH-2]) : r_work[WIDTH-1];

`ifdef LEAD_NORM_SKIP4_EN
  // Four bits can be dropped only if at least four redundant bits sit above the first significant one.
  assign w_skip = r_signed ? ((r_work[WIDTH-1:WIDTH-5] == 5'b00000) ||
                              (r_work[WIDTH-1:WIDTH-5] == 5'b11111))
                           : (r_work[WIDTH-1:WIDTH-4] == 4'b0000);
`else
  assign w_skip = 1'b0;
`endif

  assign w_work_nxt = w_skip ? {r_work[WIDTH-5:0], 4'b0000} : {r_work[WIDTH-2:0], 1'b0};
  assign w_cnt_nxt  = r_cnt + (w_skip ? 8'd4 : 8'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_special ? DONE : BUSY;
      BUSY:    if (w_stop) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work   <= in_data;
      r_signed <= in_signed;
      r_cnt    <= 8'd0;
    end else if (r_state == BUSY && !w_stop) begin
      r_work <= w_work_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_cnt  <= 8'd0;
    end else if (w_accept && w_special) begin
      r_out_data <= w_spec_data;
      r_out_cnt  <= w_spec_cnt;
    end else if (r_state == BUSY && w_stop) begin
      r_out_data <= r_work;
      r_out_cnt  <= r_cnt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_lead_norm_seq.sv
// Directed bench for lead_norm_seq: 32-bit vectors with hand-computed count/word/latency, plus one 64-bit case.
module tb_lead_norm_seq;

`ifdef LEAD_NORM_SKIP4_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [7:0]  out_cnt;

  logic        v64_in_valid, v64_in_ready, v64_in_signed, v64_out_valid, v64_out_ready;
  logic [63:0] v64_in_data, v64_out_data;
  logic [7:0]  v64_out_cnt;

  always #5 clk = ~clk;

  lead_norm_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  lead_norm_seq #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(v64_in_valid), .in_ready(v64_in_ready), .in_data(v64_in_data),
    .in_signed(v64_in_signed), .out_valid(v64_out_valid), .out_ready(v64_out_ready),
    .out_data(v64_out_data), .out_cnt(v64_out_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic [7:0]  c;
    logic [31:0] q;
    int          lat1;
    int          lat4;
    int          hold;
  } vec_t;

  vec_t tv[10];

  task automatic run(input int idx);
    vec_t v;
    int   lat;
    int   elat;
    v    = tv[idx];
    elat = SKIP ? v.lat4 : v.lat1;
    @(negedge clk);
    check($sformatf("v%0d in_ready_idle", idx), in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = v.d;
    in_signed = v.s;
    out_ready = 1'b0;
    @(negedge clk);
    // Keep junk on the input while the job runs; it must be ignored.
    in_data   = ~v.d;
    in_signed = ~v.s;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", idx), lat, elat);
    check($sformatf("v%0d cnt", idx), out_cnt, v.c);
    check($sformatf("v%0d data", idx), out_data, v.q);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = in_data + 32'h0101_0101;
      check($sformatf("v%0d bp_valid%0d", idx, h), out_valid, 1'b1);
      check($sformatf("v%0d bp_ready%0d", idx, h), in_ready, 1'b0);
      check($sformatf("v%0d bp_cnt%0d", idx, h), out_cnt, v.c);
      check($sformatf("v%0d bp_data%0d", idx, h), out_data, v.q);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d valid_drop", idx), out_valid, 1'b0);
    check($sformatf("v%0d back_idle", idx), in_ready, 1'b1);
  endtask

  initial begin
    logic seen;
    int   lat;

    tv[0] = '{32'h0001_0000, 1'b0, 8'd15, 32'h8000_0000, 17,  8, 0};
    tv[1] = '{32'h0000_0000, 1'b0, 8'd32, 32'h0000_0000,  1,  1, 0};
    tv[2] = '{32'h8000_0000, 1'b0, 8'd0,  32'h8000_0000,  2,  2, 0};
    tv[3] = '{32'hFFFF_0000, 1'b1, 8'd15, 32'h8000_0000, 17,  8, 0};
    tv[4] = '{32'h0000_0001, 1'b1, 8'd30, 32'h4000_0000, 32, 11, 0};
    tv[5] = '{32'hFFFF_FFFF, 1'b1, 8'd31, 32'h8000_0000,  1,  1, 0};
    tv[6] = '{32'h00F0_0000, 1'b0, 8'd8,  32'hF000_0000, 10,  4, 5};
    tv[7] = '{32'h1234_5678, 1'b0, 8'd3,  32'h91A2_B3C0,  5,  5, 0};
    tv[8] = '{32'h7FFF_FFFF, 1'b1, 8'd0,  32'h7FFF_FFFF,  2,  2, 0};
    tv[9] = '{32'h0000_0000, 1'b1, 8'd31, 32'h0000_0000,  1,  1, 0};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
    v64_in_valid = 1'b0; v64_in_data = '0; v64_in_signed = 1'b0; v64_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_cnt", out_cnt, 8'd0);
    check("rst out_data", out_data, 32'h0);
    check("rst64 in_ready", v64_in_ready, 1'b1);
    check("rst64 out_valid", v64_out_valid, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(i);

    // Abort a BUSY job for 0x00000100 three cycles in.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0100; in_signed = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort busy", in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", in_ready, 1'b1);
    check("abort out_valid", out_valid, 1'b0);
    check("abort out_cnt", out_cnt, 8'd0);
    check("abort out_data", out_data, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort no_result", seen, 1'b0);
    run(7);

    // 64-bit instance
    @(negedge clk);
    check("w64 in_ready", v64_in_ready, 1'b1);
    v64_in_valid = 1'b1; v64_in_data = 64'h0000_0001_0000_0000; v64_in_signed = 1'b0;
    @(negedge clk);
    v64_in_valid = 1'b0;
    lat = 1;
    while (!v64_out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("w64 latency", lat, SKIP ? 12 : 33);
    check("w64 cnt", v64_out_cnt, 8'd31);
    check("w64 data", v64_out_data, 64'h8000_0000_0000_0000);
    v64_out_ready = 1'b1;
    @(negedge clk);
    v64_out_ready = 1'b0;
    check("w64 valid_drop", v64_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
